pixel_streamer: RTL and testbench

Frame source for the cnn_layer1 datapath. On `pxs_start_i` it reads an IMG_W x IMG_H image from a synchronous single-port pixel memory in raster order. It drives each pixel, with a one-cycle enable pulse and position tags, into the enabled-register (`dff_en`) pipeline at the layer input. A hold input lets the consumer pause issue without losing or duplicating pixels.

---
 rtl/pixel_streamer.sv | 167 ++++++++++++++++
 tb/tb_pixel_streamer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// Raster-order frame reader: issues pixel-memory reads, aligns the returned data with
// position tags through a one-stage delay, and presents each pixel with a one-cycle enable.
module pixel_streamer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int IMG_W      = 32,
  parameter  int IMG_H      = 32,
  parameter  int ADDR_WIDTH = 10,
  localparam int ROW_W      = $clog2(IMG_H),
  localparam int COL_W      = $clog2(IMG_W)
) (
  input  logic                  pxs_clk,
  input  logic                  pxs_rst,
  input  logic                  pxs_start_i,
  input  logic                  pxs_hold_i,
  output logic                  pxs_rd_en_o,
  output logic [ADDR_WIDTH-1:0] pxs_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] pxs_rd_data_i,
  output logic                  pxs_en_o,
  output logic [DATA_WIDTH-1:0] pxs_data_o,
  output logic [ROW_W-1:0]      pxs_row_o,
  output logic [COL_W-1:0]      pxs_col_o,
  output logic                  pxs_sof_o,
  output logic                  pxs_eol_o,
  output logic                  pxs_eof_o,
  output logic                  pxs_busy_o,
  output logic                  pxs_done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [ROW_W-1:0]      row_cnt;
  logic [COL_W-1:0]      col_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  // Position and tags of the read currently on the memory bus (aligned with pxs_rd_en_o).
  logic [ROW_W-1:0]      iss_row;
  logic [COL_W-1:0]      iss_col;
  logic                  iss_sof;
  logic                  iss_eol;
  logic                  iss_eof;

  // Second stage: aligned with pxs_rd_data_i.
  logic                  dly_valid;
  logic [ROW_W-1:0]      dly_row;
  logic [COL_W-1:0]      dly_col;
  logic                  dly_sof;
  logic                  dly_eol;
  logic                  dly_eof;

  logic                  last_col;
  logic                  last_row;
  logic                  first_px;

  assign last_col = (col_cnt == COL_W'(IMG_W - 1));
  assign last_row = (row_cnt == ROW_W'(IMG_H - 1));
  assign first_px = (row_cnt == '0) && (col_cnt == '0);

  always_ff @(posedge pxs_clk or posedge pxs_rst) begin
    if (pxs_rst) begin
      state         <= IDLE;
      row_cnt       <= '0;
      col_cnt       <= '0;
      addr_cnt      <= '0;
      pxs_rd_en_o   <= 1'b0;
      pxs_rd_addr_o <= '0;
      iss_row       <= '0;
      iss_col       <= '0;
      iss_sof       <= 1'b0;
      iss_eol       <= 1'b0;
      iss_eof       <= 1'b0;
      pxs_busy_o    <= 1'b0;
      pxs_done_o    <= 1'b0;
    end else begin
      pxs_rd_en_o <= 1'b0;
      pxs_done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (pxs_start_i) begin
            state      <= ISSUE;
            row_cnt    <= '0;
            col_cnt    <= '0;
            addr_cnt   <= '0;
            pxs_busy_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (!pxs_hold_i) begin
            pxs_rd_en_o   <= 1'b1;
            pxs_rd_addr_o <= addr_cnt;
            iss_row       <= row_cnt;
            iss_col       <= col_cnt;
            iss_sof       <= first_px;
            iss_eol       <= last_col;
            iss_eof       <= last_col && last_row;
            addr_cnt      <= addr_cnt + ADDR_WIDTH'(1);
            if (last_col) begin
              col_cnt <= '0;
              if (last_row) begin
                row_cnt <= '0;
                state   <= DRAIN;
              end else begin
                row_cnt <= row_cnt + ROW_W'(1);
              end
            end else begin
              col_cnt <= col_cnt + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          // The final pixel is on the outputs this cycle; close the frame on the next edge.
          if (pxs_en_o && pxs_eof_o) begin
            state      <= IDLE;
            pxs_busy_o <= 1'b0;
            pxs_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pxs_clk or posedge pxs_rst) begin
    if (pxs_rst) begin
      dly_valid  <= 1'b0;
      dly_row    <= '0;
      dly_col    <= '0;
      dly_sof    <= 1'b0;
      dly_eol    <= 1'b0;
      dly_eof    <= 1'b0;
      pxs_en_o   <= 1'b0;
      pxs_data_o <= '0;
      pxs_row_o  <= '0;
      pxs_col_o  <= '0;
      pxs_sof_o  <= 1'b0;
      pxs_eol_o  <= 1'b0;
      pxs_eof_o  <= 1'b0;
    end else begin
      dly_valid <= pxs_rd_en_o;
      dly_row   <= iss_row;
      dly_col   <= iss_col;
      dly_sof   <= iss_sof;
      dly_eol   <= iss_eol;
      dly_eof   <= iss_eof;
      if (dly_valid) begin
        pxs_en_o   <= 1'b1;
        pxs_data_o <= pxs_rd_data_i;
        pxs_row_o  <= dly_row;
        pxs_col_o  <= dly_col;
        pxs_sof_o  <= dly_sof;
        pxs_eol_o  <= dly_eol;
        pxs_eof_o  <= dly_eof;
      end else begin
        // Data and position hold their last value; only the qualifiers drop.
        pxs_en_o  <= 1'b0;
        pxs_sof_o <= 1'b0;
        pxs_eol_o <= 1'b0;
        pxs_eof_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer: directed scenarios plus random hold/start/reset traffic,
// checked every cycle against a pixel-index timeline model of the frame.
module tb_pixel_streamer;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          en;
  logic [DW-1:0] data;
  logic [1:0]    row;
  logic [1:0]    col;
  logic          sof, eol, eof, busy, done;

  logic [DW-1:0] mem [0:15];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: a frame is a sequence of pixel indices; each issued index surfaces two edges later.
  bit            m_busy, m_issuing, m_rd_en, m_en, m_done;
  int            m_issued, m_addr, m_idx, m_row, m_col;
  logic [DW-1:0] m_data;
  bit            hv [3];
  int            hi [3];

  // Per-frame observation log.
  int mon_n, mon_done_cnt, mon_done_cyc;
  int mon_cyc [16];
  int mon_data [16];

  always #5 clk = ~clk;

  pixel_streamer #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)) dut (
    .pxs_clk(clk), .pxs_rst(rst), .pxs_start_i(start), .pxs_hold_i(hold),
    .pxs_rd_en_o(rd_en), .pxs_rd_addr_o(rd_addr), .pxs_rd_data_i(rd_data),
    .pxs_en_o(en), .pxs_data_o(data), .pxs_row_o(row), .pxs_col_o(col),
    .pxs_sof_o(sof), .pxs_eol_o(eol), .pxs_eof_o(eof),
    .pxs_busy_o(busy), .pxs_done_o(done)
  );

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_issuing = 0; m_rd_en = 0; m_en = 0; m_done = 0;
    m_issued = 0; m_addr = 0; m_idx = 0; m_row = 0; m_col = 0; m_data = '0;
    for (int i = 0; i < 3; i++) begin hv[i] = 0; hi[i] = 0; end
  endtask

  task automatic model_step();
    bit prev_en, issue, busy_old;
    int prev_idx;
    if (rst) begin model_clear(); return; end
    prev_en  = m_en;
    prev_idx = m_idx;
    issue    = m_issuing && !hold;
    hv[2] = hv[1]; hi[2] = hi[1];
    hv[1] = hv[0]; hi[1] = hi[0];
    hv[0] = issue; hi[0] = m_issued;
    m_rd_en = issue;
    if (issue) begin
      m_addr = m_issued;
      m_issued++;
      if (m_issued == N) m_issuing = 0;
    end
    m_en = hv[2];
    if (m_en) begin
      m_idx  = hi[2];
      m_data = mem[hi[2]];
      m_row  = hi[2] / W;
      m_col  = hi[2] % W;
    end
    m_done   = prev_en && (prev_idx == N - 1);
    busy_old = m_busy;
    if (m_done) m_busy = 0;
    if (!busy_old && start) begin
      m_busy = 1; m_issuing = 1; m_issued = 0;
    end
  endtask

  task automatic compare();
    chk("rd_en",   int'(rd_en),   int'(m_rd_en));
    chk("rd_addr", int'(rd_addr), m_addr);
    chk("en",      int'(en),      int'(m_en));
    chk("data",    int'(data),    int'(m_data));
    chk("row",     int'(row),     m_row);
    chk("col",     int'(col),     m_col);
    chk("sof",     int'(sof),     int'(m_en && m_idx == 0));
    chk("eol",     int'(eol),     int'(m_en && m_col == W - 1));
    chk("eof",     int'(eof),     int'(m_en && m_idx == N - 1));
    chk("busy",    int'(busy),    int'(m_busy));
    chk("done",    int'(done),    int'(m_done));
    if (en) begin
      if (mon_n < 16) begin mon_cyc[mon_n] = cyc; mon_data[mon_n] = int'(data); end
      mon_n++;
    end
    if (done) begin mon_done_cnt++; mon_done_cyc = cyc; end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      compare();
    end
  end

  task automatic clear_mon();
    mon_n = 0; mon_done_cnt = 0; mon_done_cyc = -1;
  endtask

  task automatic start_frame(output int e0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_timeout", int'(seen), 1);
  endtask

  task automatic check_seq(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (mon_data[i] != i + 1) bad++;
    chk(name, bad, 0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, int'({rd_en, rd_addr, en, data, row, col, sof, eol, eof, busy, done}), 0);
  endtask

  initial begin
    int e0, e1, ok;
    for (int a = 0; a < 16; a++) mem[a] = DW'(a + 1);
    mon_n = 0; mon_done_cnt = 0; mon_done_cyc = -1;

    // Reset with random inputs; start must be ignored while reset is high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom % 2);
      hold  = 1'($urandom % 2);
    end
    check_all_zero("reset_outputs");
    start = 1'b0; hold = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_start_from_reset", int'(busy), 0);

    // Basic frame.
    clear_mon();
    start_frame(e0);
    wait_done(40);
    repeat (2) @(negedge clk);
    chk("basic_count", mon_n, 12);
    chk("basic_first_latency", mon_cyc[0] - e0, 3);
    chk("basic_last_cycle", mon_cyc[11] - e0, 14);
    chk("basic_done_cycle", mon_done_cyc - e0, 15);
    chk("basic_eol_row0", mon_data[3], 4);
    chk("basic_eol_row1", mon_data[7], 8);
    chk("basic_eof_data", mon_data[11], 12);
    check_seq("basic_seq");

    // Hold at the two edges after the one issuing address 5.
    clear_mon();
    start_frame(e0);
    wait_to(e0 + 6);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    hold = 1'b0;
    wait_done(40);
    repeat (2) @(negedge clk);
    chk("hold_count", mon_n, 12);
    chk("hold_px6_cycle", mon_cyc[5] - e0, 8);
    chk("hold_px7_cycle", mon_cyc[6] - e0, 11);
    chk("hold_done_cycle", mon_done_cyc - e0, 17);
    check_seq("hold_seq");

    // Start during ISSUE and DRAIN ignored; start in the done cycle launches the next frame.
    clear_mon();
    start_frame(e0);
    wait_to(e0 + 4);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_to(e0 + 12);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(40);
    start = 1'b1; @(negedge clk); start = 1'b0;
    e1 = cyc;
    chk("busy_start_count", mon_n, 12);
    chk("busy_start_dones", mon_done_cnt, 1);
    chk("busy_start_done_cycle", mon_done_cyc - e0, 15);
    clear_mon();
    wait_done(40);
    chk("b2b_first_latency", mon_cyc[0] - e1, 3);
    chk("b2b_count", mon_n, 12);

    // Reset right after the pixel with data 5 is presented.
    clear_mon();
    start_frame(e0);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (en && data == 8'd5) ok = 1;
    end
    chk("rst_mid_reach5", ok, 1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_outputs");
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_count", mon_n, 5);
    chk("rst_mid_no_done", mon_done_cnt, 0);
    clear_mon();
    start_frame(e0);
    wait_done(40);
    chk("rst_restart_latency", mon_cyc[0] - e0, 3);
    check_seq("rst_restart_seq");

    // Hold high from the start edge through E4.
    clear_mon();
    @(negedge clk); start = 1'b1; hold = 1'b1;
    @(negedge clk); start = 1'b0;
    e0 = cyc;
    wait_to(e0 + 4);
    hold = 1'b0;
    wait_done(40);
    chk("hold_start_first", mon_cyc[0] - e0, 7);
    chk("hold_start_done", mon_done_cyc - e0, 19);
    check_seq("hold_start_seq");

    // Random traffic: hold, stray starts, occasional reset, memory refreshed while idle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      hold  = ($urandom % 4 == 0);
      start = ($urandom % 6 == 0);
      rst   = ($urandom % 200 == 0);
      if (!busy) mem[$urandom % 16] = DW'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; hold = 1'b0; start = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
